my_xor2_arbiter: RTL and testbench

Round-robin scheduler that shares one registered XOR2 unit (`MY_XOR2_WDFF`: CLK, RESET, CE, IN_A, IN_B, O) among `N_REQ` bit-serial requesters. The block arbitrates per-cycle requests and drives the unit's CE and operand inputs. It tags each issued operation with the requester ID and returns the unit's output as a response stream. It sits between the sampler lanes and the single shared XOR2 cell.

---
 rtl/my_xor2_arb_pkg.sv | 32 +++
 rtl/my_rr_pick.sv | 46 ++++
 rtl/my_xor2_arbiter.sv | 153 +++++++++++++++
 tb/tb_my_xor2_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/my_xor2_arb_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the XOR2 round-robin scheduler.
// The optional grant-hold feature is enabled by defining MY_XOR2_ARB_LOCK_EN.
package my_xor2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int DEFAULT_N_REQ = 4;

  // Two stages (CE stage, response stage) bound the in-flight count to 0..2.
  localparam int INFLIGHT_W = 2;

  function automatic logic [INFLIGHT_W-1:0] inflight_step(
    input logic [INFLIGHT_W-1:0] cnt,
    input logic                  inc,
    input logic                  dec
  );
    logic [INFLIGHT_W-1:0] res;
    res = cnt;
    case ({inc, dec})
      2'b10:   res = cnt + INFLIGHT_W'(1);
      2'b01:   res = cnt - INFLIGHT_W'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/my_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin selector: the search starts one past ptr and the
// first valid requester wins; grant is one-hot or zero.
module my_rr_pick
  import my_xor2_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int off);
    int s;
    s = int'(p) + 1 + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  logic [ID_W-1:0]  idx [N_REQ];
  logic [N_REQ-1:0] rot_valid;

  // rot_valid[k] is the requester k+1 positions after the pointer
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign idx[gi]       = wrap_idx(ptr, gi);
    assign rot_valid[gi] = valid[idx[gi]];
  end

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        winner = idx[k];
        any    = 1'b1;
      end
    end
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/my_xor2_arbiter.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one registered XOR2 cell among N_REQ requesters.
// Define MY_XOR2_ARB_LOCK_EN to let a requester hold the grant with REQ_LOCK.
module my_xor2_arbiter
  import my_xor2_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [N_REQ-1:0] REQ_VALID,
  input  logic [N_REQ-1:0] REQ_A,
  input  logic [N_REQ-1:0] REQ_B,
  input  logic [N_REQ-1:0] REQ_LOCK,
  output logic [N_REQ-1:0] REQ_READY,
  output logic             XOR_CE,
  output logic             XOR_A,
  output logic             XOR_B,
  input  logic             XOR_O,
  output logic             RSP_VALID,
  output logic [ID_W-1:0]  RSP_ID,
  output logic             RSP_O,
  output logic             BUSY
);

  arb_state_t            state_reg;
  logic [ID_W-1:0]       ptr_reg;
  logic [INFLIGHT_W-1:0] inflight_reg;
  logic [INFLIGHT_W-1:0] inflight_next;
  logic                  xor_ce_reg;
  logic                  xor_a_reg;
  logic                  xor_b_reg;
  logic [ID_W-1:0]       issue_id_reg;
  logic                  rsp_valid_reg;
  logic [ID_W-1:0]       rsp_id_reg;

  logic [N_REQ-1:0] rr_grant;
  logic [ID_W-1:0]  rr_winner;
  logic             rr_any;

  logic [N_REQ-1:0] sel_grant;
  logic [ID_W-1:0]  sel_id;
  logic             sel_any;
  logic             run;
  logic             issue;

  my_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid  (REQ_VALID),
    .ptr    (ptr_reg),
    .grant  (rr_grant),
    .winner (rr_winner),
    .any    (rr_any)
  );

`ifdef MY_XOR2_ARB_LOCK_EN
  logic            lock_active_reg;
  logic [ID_W-1:0] lock_id_reg;
  logic            lock_hold;

  assign lock_hold = lock_active_reg & REQ_VALID[lock_id_reg] & REQ_LOCK[lock_id_reg];

  always_comb begin
    sel_grant = rr_grant;
    sel_id    = rr_winner;
    sel_any   = rr_any;
    if (lock_hold) begin
      sel_grant              = '0;
      sel_grant[lock_id_reg] = 1'b1;
      sel_id                 = lock_id_reg;
      sel_any                = 1'b1;
    end
  end

  // Lock only survives back-to-back issues; any idle or non-RUN cycle drops it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_active_reg <= 1'b0;
      lock_id_reg     <= '0;
    end else if (issue) begin
      lock_active_reg <= REQ_LOCK[sel_id];
      lock_id_reg     <= sel_id;
    end else begin
      lock_active_reg <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^REQ_LOCK;

  always_comb begin
    sel_grant = rr_grant;
    sel_id    = rr_winner;
    sel_any   = rr_any;
  end
`endif

  assign run           = (state_reg == RUN);
  assign issue         = run & sel_any;
  assign inflight_next = inflight_step(inflight_reg, issue, rsp_valid_reg);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      ptr_reg       <= ID_W'(N_REQ - 1);
      inflight_reg  <= '0;
      xor_ce_reg    <= 1'b0;
      xor_a_reg     <= 1'b0;
      xor_b_reg     <= 1'b0;
      issue_id_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE:    if (EN) state_reg <= RUN;
        RUN:     if (!EN) state_reg <= DRAIN;
        DRAIN: begin
          if (EN)                      state_reg <= RUN;
          else if (inflight_next == '0) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      xor_ce_reg <= issue;
      if (issue) begin
        xor_a_reg    <= REQ_A[sel_id];
        xor_b_reg    <= REQ_B[sel_id];
        issue_id_reg <= sel_id;
        ptr_reg      <= sel_id;
      end

      // The cell captures while CE is high, so its output is the response next cycle.
      rsp_valid_reg <= xor_ce_reg;
      if (xor_ce_reg) rsp_id_reg <= issue_id_reg;

      inflight_reg <= inflight_next;
    end
  end

  assign REQ_READY = run ? sel_grant : '0;
  assign XOR_CE    = xor_ce_reg;
  assign XOR_A     = xor_a_reg;
  assign XOR_B     = xor_b_reg;
  assign RSP_VALID = rsp_valid_reg;
  assign RSP_ID    = rsp_id_reg;
  assign RSP_O     = XOR_O;
  assign BUSY      = (state_reg != IDLE) | (inflight_reg != '0);

endmodule

// File: tb/tb_my_xor2_arbiter.sv
`timescale 1ns/1ps
// Directed bench for my_xor2_arbiter with a behavioural model of the shared XOR2 cell.
module tb_my_xor2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] valid, a, b, lock;
  logic [3:0] ready;
  logic       xor_ce, xor_a, xor_b, xor_o;
  logic       rsp_valid, rsp_o, busy;
  logic [1:0] rsp_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  my_xor2_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .CLK(clk), .RESET(rst), .EN(en),
    .REQ_VALID(valid), .REQ_A(a), .REQ_B(b), .REQ_LOCK(lock),
    .REQ_READY(ready), .XOR_CE(xor_ce), .XOR_A(xor_a), .XOR_B(xor_b), .XOR_O(xor_o),
    .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_O(rsp_o), .BUSY(busy)
  );

  // Shared registered XOR2 cell
  always @(posedge clk or posedge rst) begin
    if (rst) xor_o <= 1'b0;
    else if (xor_ce) xor_o <= xor_a ^ xor_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic [3:0] valid, a, b, ready;
    logic       ce, rv;
    logic [1:0] rid;
    logic       ro, busy;
  } vec_t;

  function automatic vec_t mk(logic e, logic [3:0] v, logic [3:0] aa, logic [3:0] bb,
                              logic [3:0] r, logic c, logic rv, logic [1:0] ri,
                              logic ro, logic bz);
    vec_t t;
    t.en = e; t.valid = v; t.a = aa; t.b = bb; t.ready = r;
    t.ce = c; t.rv = rv; t.rid = ri; t.ro = ro; t.busy = bz;
    return t;
  endfunction

  vec_t tbl [19];

  typedef struct { logic [1:0] id; logic o; int due; } exp_t;
  exp_t       q [$];
  int         cyc = 0;
  int         max_q = 0;
  logic [3:0] opa = 4'h0, opb = 4'h0, refresh = 4'hf;

  task automatic stress_cycle(input logic en_v, input logic [3:0] valid_v);
    exp_t e;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      if (refresh[r]) begin
        opa[r] = 1'($urandom_range(0, 1));
        opb[r] = 1'($urandom_range(0, 1));
      end
    end
    refresh = 4'h0;
    en = en_v; valid = valid_v; a = opa; b = opb;
    @(negedge clk);
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("stress unexpected rsp", 32'(rsp_valid), 32'(0));
      end else begin
        e = q.pop_front();
        chk($sformatf("stress rsp_id c%0d", cyc), 32'(rsp_id), 32'(e.id));
        chk($sformatf("stress rsp_o c%0d", cyc), 32'(rsp_o), 32'(e.o));
        chk($sformatf("stress latency c%0d", cyc), 32'(cyc), 32'(e.due));
      end
    end
    if (|(ready & valid)) begin
      chk($sformatf("stress onehot c%0d", cyc), 32'($onehot(ready)), 32'(1));
      for (int r = 0; r < 4; r++) begin
        if (ready[r]) begin
          e.id = 2'(r); e.o = opa[r] ^ opb[r]; e.due = cyc + 2;
          q.push_back(e);
        end
      end
      refresh = ready;
    end
    if (q.size() > max_q) max_q = q.size();
    cyc++;
  endtask

  int lock_exp [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; valid = 4'h0; a = 4'h0; b = 4'h0; lock = 4'h0;

    //            en  valid    a        b        ready    ce rv rid ro busy
    tbl[0]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'b1111, 4'b1010, 4'b0110, 4'b0001, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 4'b1111, 4'b1010, 4'b0110, 4'b0010, 1, 0, 0, 0, 1);
    tbl[3]  = mk(1, 4'b1111, 4'b1010, 4'b0110, 4'b0100, 1, 1, 0, 0, 1);
    tbl[4]  = mk(1, 4'b1111, 4'b1010, 4'b0110, 4'b1000, 1, 1, 1, 0, 1);
    tbl[5]  = mk(1, 4'b1111, 4'b1010, 4'b0110, 4'b0001, 1, 1, 2, 1, 1);
    tbl[6]  = mk(1, 4'b0000, 4'b1010, 4'b0110, 4'b0000, 1, 1, 3, 1, 1);
    tbl[7]  = mk(1, 4'b0000, 4'b1010, 4'b0110, 4'b0000, 0, 1, 0, 0, 1);
    tbl[8]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 0, 1);
    tbl[11] = mk(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 0, 1, 2, 1, 1);
    tbl[12] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    tbl[13] = mk(1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 0, 1);
    tbl[15] = mk(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1, 0, 0, 1);
    tbl[16] = mk(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 1, 1, 1, 1);
    tbl[17] = mk(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

`ifdef MY_XOR2_ARB_LOCK_EN
    lock_exp = '{1, 1, 1, 1, 1, 3, 0};
`else
    lock_exp = '{1, 3, 0, 1, 3, 0, 3};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(ready), 32'(0));
    chk("reset xor_ce", 32'(xor_ce), 32'(0));
    chk("reset xor_a", 32'(xor_a), 32'(0));
    chk("reset xor_b", 32'(xor_b), 32'(0));
    chk("reset rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset rsp_id", 32'(rsp_id), 32'(0));
    chk("reset rsp_o", 32'(rsp_o), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Table: round robin, single request latency, EN drop drain
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      en = tbl[i].en; valid = tbl[i].valid; a = tbl[i].a; b = tbl[i].b;
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(ready), 32'(tbl[i].ready));
      chk($sformatf("row%0d xor_ce", i), 32'(xor_ce), 32'(tbl[i].ce));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].rv) begin
        chk($sformatf("row%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].rid));
        chk($sformatf("row%0d rsp_o", i), 32'(rsp_o), 32'(tbl[i].ro));
      end
    end

    // Reset pulse with operations in flight
    @(posedge clk); #1;
    en = 1'b1; valid = 4'b1111; a = 4'b1111; b = 4'b0000;
    @(negedge clk);
    chk("rst seq idle ready", 32'(ready), 32'(0));
    @(posedge clk);
    @(negedge clk);
    chk("rst seq grant2", 32'(ready), 32'(4'b0100));
    @(posedge clk); #1;
    chk("rst seq ce before", 32'(xor_ce), 32'(1));
    #1 rst = 1'b1;
    #0.1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready", 32'(ready), 32'(0));
    chk("post-rst xor_ce", 32'(xor_ce), 32'(0));
    chk("post-rst xor_a", 32'(xor_a), 32'(0));
    chk("post-rst xor_b", 32'(xor_b), 32'(0));
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'(0));
    chk("post-rst rsp_id", 32'(rsp_id), 32'(0));
    chk("post-rst busy", 32'(busy), 32'(0));
    @(posedge clk);
    @(negedge clk);
    chk("post-rst first grant", 32'(ready), 32'(4'b0001));
    chk("post-rst no rsp 1", 32'(rsp_valid), 32'(0));
    chk("post-rst no ce", 32'(xor_ce), 32'(0));

    // Lock / round-robin sequence, pointer now at requester 0
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k < 5) begin valid = 4'b1011; lock = 4'b0010; end
      else       begin valid = 4'b1001; lock = 4'b0000; end
      @(negedge clk);
      if (k == 0) chk("post-rst no rsp 2", 32'(rsp_valid), 32'(0));
      chk($sformatf("lock seq grant%0d", k), 32'(ready), 32'(1) << lock_exp[k]);
    end
    @(posedge clk); #1;
    valid = 4'h0; lock = 4'h0;
    repeat (4) @(posedge clk);

    // EN toggling every 10 cycles under continuous requests
    for (int k = 0; k < 200; k++) stress_cycle(((k / 10) % 2) == 0, 4'hf);
    for (int k = 0; k < 5; k++) stress_cycle(1'b0, 4'h0);
    chk("stress all responded", 32'(q.size()), 32'(0));
    chk("stress max inflight<=2", 32'(max_q <= 2), 32'(1));
    chk("stress final busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
